// File: rtl/wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// wb_trace_fifo
//
// Writeback-commit trace buffer. Sits beside the CPU core on its debug_wb_*
// commit interface. Each qualifying commit (selected by trace_mode) is stored
// with a retire sequence number. A debug host drains the buffer through a
// first-word-fall-through valid/ready port.
//
// Handshake (out_*): the head entry is presented whenever out_valid=1. The
// entry transfers on a rising edge where out_valid=1 and out_ready=1. While
// out_valid=1 and out_ready=0, every out_* field holds its value. out_valid
// does not depend combinationally on out_ready.
//
// Ports
//   clk, rst_n         core clock, asynchronous active-low reset
//   wb_have_inst       a commit occurs this cycle
//   wb_pc/ena/reg/value  fields of the committing instruction
//   trace_mode         0=off, 1=all, 2=writes only, 3=writes to reg!=0
//   flush              synchronous clear of FIFO contents
//   clr_ovf            synchronous clear of overflow and drop_cnt
//   out_valid/ready    head entry handshake
//   out_seq/pc/ena/reg/value  head entry fields
//   level              entries currently held
//   overflow           sticky: a qualifying commit was dropped
//   drop_cnt           saturating count of dropped qualifying commits
//   retired            wrapping count of all commits seen
// ---------------------------------------------------------------------------
module wb_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_have_inst,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic                     wb_ena,
  input  logic [4:0]               wb_reg,
  input  logic [XLEN-1:0]          wb_value,
  input  logic [1:0]               trace_mode,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_seq,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_ena,
  output logic [4:0]               out_reg,
  output logic [XLEN-1:0]          out_value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         retired
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic             ena;
    logic [4:0]       rd;
    logic [XLEN-1:0]  value;
  } entry_t;

  entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic qual;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    qual = 1'b0;
    case (trace_mode)
      2'd1:    qual = wb_have_inst;
      2'd2:    qual = wb_have_inst & wb_ena;
      2'd3:    qual = wb_have_inst & wb_ena & (wb_reg != 5'd0);
      default: qual = 1'b0;
    endcase
  end

  // Power-of-two depth makes the pointer difference the occupancy directly.
  assign level     = wr_ptr - rd_ptr;
  assign out_valid = (level != '0);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flush wins over both sides. A pop in the same cycle frees the slot a
  // push into a full FIFO needs, so that push is accepted.
  assign pop  = out_valid & out_ready & ~flush;
  assign push = qual & (~full | pop) & ~flush;
  // A commit discarded by a flush is not an overflow.
  assign drop = qual & ~push & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage has no reset; contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{seq:   retired,
                               pc:    wb_pc,
                               ena:   wb_ena,
                               rd:    wb_reg,
                               value: wb_value};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (wb_have_inst) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // A drop in the same cycle as clr_ovf leaves exactly that one drop counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  entry_t head;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_seq   = head.seq;
  assign out_pc    = head.pc;
  assign out_ena   = head.ena;
  assign out_reg   = head.rd;
  assign out_value = head.value;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_fifo
//
// Directed bench for wb_trace_fifo (XLEN=32, DEPTH=16, CNT_W=32). Inputs are
// driven and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge in between.
// ---------------------------------------------------------------------------
module tb_wb_trace_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int W     = 64;   // scoreboard entry: {seq, pc}

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_have_inst;
  logic [XLEN-1:0]   wb_pc;
  logic              wb_ena;
  logic [4:0]        wb_reg;
  logic [XLEN-1:0]   wb_value;
  logic [1:0]        trace_mode;
  logic              flush;
  logic              clr_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_seq;
  logic [XLEN-1:0]   out_pc;
  logic              out_ena;
  logic [4:0]        out_reg;
  logic [XLEN-1:0]   out_value;
  logic [4:0]        level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  retired;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  wb_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_have_inst (wb_have_inst),
    .wb_pc        (wb_pc),
    .wb_ena       (wb_ena),
    .wb_reg       (wb_reg),
    .wb_value     (wb_value),
    .trace_mode   (trace_mode),
    .flush        (flush),
    .clr_ovf      (clr_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_seq      (out_seq),
    .out_pc       (out_pc),
    .out_ena      (out_ena),
    .out_reg      (out_reg),
    .out_value    (out_value),
    .level        (level),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .retired      (retired)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wb_have_inst = 1'b0;
    wb_pc        = '0;
    wb_ena       = 1'b0;
    wb_reg       = '0;
    wb_value     = '0;
    flush        = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  task automatic drive_commit(input logic [31:0] pc, input logic ena,
                              input logic [4:0] rg, input logic [31:0] val);
    wb_have_inst = 1'b1;
    wb_pc        = pc;
    wb_ena       = ena;
    wb_reg       = rg;
    wb_value     = val;
  endtask

  // One rising edge with the current inputs, then back to idle commit lines.
  task automatic tick();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_reset();
    drive_idle();
    out_ready  = 1'b0;
    trace_mode = 2'd0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;

    do_reset();
    check("rst_level",    64'(level),     64'd0);
    check("rst_valid",    64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    check("rst_drop",     64'(drop_cnt),  64'd0);
    check("rst_retired",  64'(retired),   64'd0);

    // Mode 1: three commits streaming through with the host always ready.
    trace_mode = 2'd1;
    out_ready  = 1'b1;
    drive_commit(32'h0, 1'b1, 5'd1, 32'd5); tick();
    check("m1_valid0", 64'(out_valid), 64'd1);
    check("m1_seq0",   64'(out_seq),   64'd0);
    check("m1_pc0",    64'(out_pc),    64'h0);
    check("m1_ena0",   64'(out_ena),   64'd1);
    check("m1_reg0",   64'(out_reg),   64'd1);
    check("m1_val0",   64'(out_value), 64'd5);
    drive_commit(32'h4, 1'b1, 5'd2, 32'd6); tick();
    check("m1_seq1",   64'(out_seq),   64'd1);
    check("m1_pc1",    64'(out_pc),    64'h4);
    check("m1_val1",   64'(out_value), 64'd6);
    check("m1_level1", 64'(level),     64'd1);
    drive_commit(32'h8, 1'b1, 5'd3, 32'd7); tick();
    check("m1_seq2",   64'(out_seq),   64'd2);
    check("m1_pc2",    64'(out_pc),    64'h8);
    check("m1_reg2",   64'(out_reg),   64'd3);
    check("m1_val2",   64'(out_value), 64'd7);
    tick();
    check("m1_valid_end", 64'(out_valid), 64'd0);
    check("m1_level_end", 64'(level),     64'd0);
    check("m1_retired",   64'(retired),   64'd3);

    // Mode 3, then mode 0, then mode 2 filtering.
    do_reset();
    trace_mode = 2'd3;
    drive_commit(32'h24, 1'b1, 5'd0, 32'd1); tick();
    drive_commit(32'h28, 1'b0, 5'd5, 32'd2); tick();
    drive_commit(32'h2c, 1'b1, 5'd6, 32'd3); tick();
    check("m3_level",   64'(level),   64'd1);
    check("m3_seq",     64'(out_seq), 64'd2);
    check("m3_reg",     64'(out_reg), 64'd6);
    check("m3_pc",      64'(out_pc),  64'h2c);
    check("m3_retired", 64'(retired), 64'd3);
    trace_mode = 2'd0;
    drive_commit(32'h30, 1'b1, 5'd4, 32'd9); tick();
    check("m0_level",   64'(level),   64'd1);
    check("m0_retired", 64'(retired), 64'd4);
    trace_mode = 2'd2;
    drive_commit(32'h34, 1'b0, 5'd7, 32'd0);  tick();
    drive_commit(32'h38, 1'b1, 5'd0, 32'haa); tick();
    check("m2_level",   64'(level),   64'd2);
    out_ready = 1'b1; tick();
    check("m2_seq",     64'(out_seq),   64'd5);
    check("m2_pc",      64'(out_pc),    64'h38);
    check("m2_reg",     64'(out_reg),   64'd0);
    check("m2_val",     64'(out_value), 64'haa);
    tick();
    check("m2_level_end", 64'(level), 64'd0);
    out_ready = 1'b0;

    // Overflow: 18 commits into a 16-deep FIFO with no draining.
    do_reset();
    trace_mode = 2'd1;
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      drive_commit(32'(i * 4), 1'b1, 5'(i), 32'(i));
      if (i < DEPTH) exp_q.push_back({32'(i), 32'(i * 4)});
      tick();
    end
    check("ovf_level",    64'(level),     64'd16);
    check("ovf_flag",     64'(overflow),  64'd1);
    check("ovf_drop",     64'(drop_cnt),  64'd2);
    check("ovf_retired",  64'(retired),   64'd18);
    check("ovf_head_seq", 64'(out_seq),   64'd0);

    // Full FIFO, pop and commit together: push accepted, nothing dropped.
    out_ready = 1'b1;
    drive_commit(32'h1000, 1'b1, 5'd9, 32'h55);
    void'(exp_q.pop_front());
    exp_q.push_back({32'd18, 32'h1000});
    tick();
    check("fullpop_level", 64'(level),    64'd16);
    check("fullpop_drop",  64'(drop_cnt), 64'd2);
    check("fullpop_ovf",   64'(overflow), 64'd1);

    // Drain all 16 held entries in order.
    for (int k = 0; k < DEPTH; k++) begin
      e = exp_q.pop_front();
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_seq",   64'(out_seq),   64'(e[63:32]));
      check("drain_pc",    64'(out_pc),    64'(e[31:0]));
      tick();
    end
    check("drain_level_end", 64'(level),     64'd0);
    check("drain_valid_end", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure: continuous commits, out_ready alternating 0/1.
    do_reset();
    trace_mode = 2'd1;
    exp_q.delete();
    for (int k = 0; k < 24; k++) begin
      check("bp_level", 64'(level), 64'(exp_q.size()));
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_seq",   64'(out_seq),   64'(e[63:32]));
        check("bp_pc",    64'(out_pc),    64'(e[31:0]));
      end else begin
        check("bp_valid", 64'(out_valid), 64'd0);
      end
      out_ready = ((k % 2) == 1);
      drive_commit(32'h100 + 32'(k * 4), 1'b1, 5'(k), 32'(k));
      if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      exp_q.push_back({32'(k), 32'h100 + 32'(k * 4)});
      tick();
    end
    out_ready = 1'b1;
    for (int g = 0; g < 40 && exp_q.size() > 0; g++) begin
      e = exp_q.pop_front();
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_seq",   64'(out_seq),   64'(e[63:32]));
      check("bp_drain_pc",    64'(out_pc),    64'(e[31:0]));
      tick();
    end
    check("bp_level_end", 64'(level),     64'd0);
    check("bp_valid_end", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush with 5 entries held plus a same-cycle commit.
    do_reset();
    trace_mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      drive_commit(32'(i * 4), 1'b1, 5'd1, 32'(i));
      tick();
    end
    check("fl_level_pre", 64'(level), 64'd5);
    drive_commit(32'h50, 1'b1, 5'd2, 32'd1);
    flush = 1'b1;
    tick();
    check("fl_valid",   64'(out_valid), 64'd0);
    check("fl_level",   64'(level),     64'd0);
    check("fl_retired", 64'(retired),   64'd6);
    check("fl_ovf",     64'(overflow),  64'd0);

    // clr_ovf coinciding with a drop.
    for (int i = 0; i < 18; i++) begin
      drive_commit(32'(i * 4), 1'b1, 5'd3, 32'(i));
      tick();
    end
    check("co_drop_pre", 64'(drop_cnt), 64'd2);
    drive_commit(32'h200, 1'b1, 5'd3, 32'd0);
    clr_ovf = 1'b1;
    tick();
    check("co_ovf",   64'(overflow), 64'd1);
    check("co_drop",  64'(drop_cnt), 64'd1);
    check("co_level", 64'(level),    64'd16);
    clr_ovf = 1'b1;
    tick();
    check("co_clr_ovf",  64'(overflow), 64'd0);
    check("co_clr_drop", 64'(drop_cnt), 64'd0);
    check("co_retired",  64'(retired),  64'd25);

    // Reset pulse mid-stream acts without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_level",   64'(level),     64'd0);
    check("ar_valid",   64'(out_valid), 64'd0);
    check("ar_ovf",     64'(overflow),  64'd0);
    check("ar_drop",    64'(drop_cnt),  64'd0);
    check("ar_retired", 64'(retired),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Parametrised writeback-commit trace buffer that sits beside the CPU core on its debug_wb_* commit interface.
- Captures each committed instruction (pc, write enable, destination register, value) into a FIFO, tagged with a retire sequence number.
- The FIFO is drained by a debug host over a valid/ready handshake.
- Adds run-time filter modes, overflow detection, a drop counter and a flush, so multi-cycle and pipelined cores (where have_inst is not constant 1) can be traced.

Parameters:
- XLEN, 32, width of pc and value fields
- DEPTH, 16, FIFO entries; power of two, minimum 2
- CNT_W, 32, width of the retire, sequence and drop counters

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- wb_have_inst  input  1  a commit occurs this cycle
- wb_pc  input  XLEN  pc of the committing instruction
- wb_ena  input  1  register write enable of the commit
- wb_reg  input  5  destination register
- wb_value  input  XLEN  value written
- trace_mode  input  2  0=off, 1=all commits, 2=writes only (wb_ena=1), 3=writes to reg!=0 only
- flush  input  1  synchronous clear of FIFO contents
- clr_ovf  input  1  synchronous clear of overflow flag and drop counter
- out_valid  output  1  head entry available
- out_ready  input  1  host accepts head entry
- out_seq  output  CNT_W  sequence number of head entry
- out_pc  output  XLEN  head pc
- out_ena  output  1  head write enable
- out_reg  output  5  head destination register
- out_value  output  XLEN  head value
- level  output  log2(DEPTH)+1  entries held
- overflow  output  1  sticky: a qualifying commit was dropped
- drop_cnt  output  CNT_W  number of dropped qualifying commits, saturating
- retired  output  CNT_W  total commits seen (wb_have_inst=1), wrapping

Behaviour:
- Reset (rst_n=0, asynchronous): read/write pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0, retired=0. Storage contents are don't-care. out_* data fields are don't-care while out_valid=0.
- Qualify: q = wb_have_inst & (mode1 | (mode2 & wb_ena) | (mode3 & wb_ena & wb_reg!=0)). When trace_mode=0, q=0.
- retired increments on every cycle with wb_have_inst=1, regardless of mode or FIFO state. Wraps at 2^CNT_W.
- Entry seq = value of retired before that cycle's increment. The first commit after reset has seq 0. Gaps in seq indicate filtered or dropped commits.
- pop = out_valid & out_ready.
- push = q & (level<DEPTH | pop). When full, a simultaneous pop frees the slot and the push is accepted in the same cycle.
- drop = q & ~push. On drop: overflow<=1, and drop_cnt increments, saturating at all-ones.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N; no same-cycle bypass. out_* is first-word-fall-through, driven by the head entry.
- out_* stays stable while out_valid=1 and out_ready=0.
- level updates: +1 on push only, −1 on pop only, unchanged on both or neither. out_valid = (level!=0).
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.
- flush (priority over push and pop that cycle): pointers and level go to 0, out_valid goes to 0 next cycle, and the cycle's commit is not stored. retired still counts that cycle's commit. overflow and drop_cnt are unaffected.
- clr_ovf: overflow<=0 and drop_cnt<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Asserting reset mid-operation discards all contents immediately.

Test Plan:
- Mode1: commit pc 0x0,0x4,0x8 (with wb_ena=1, reg 1,2,3, values 5,6,7), out_ready=1 → three entries out with seq 0,1,2, matching fields, each 1 cycle after its commit; level returns to 0.
- Mode3: commits to reg 0 (ena=1), reg 5 (ena=0), reg 6 (ena=1) → only reg 6 entry stored, with seq=2; retired=3.
- DEPTH=16, out_ready=0, 18 qualifying commits → level=16, overflow=1, drop_cnt=2. Then drain: 16 entries out with seq 0..15.
- Full FIFO plus a commit with out_ready=1 in the same cycle → push accepted, level stays 16, no drop, drop_cnt unchanged.
- Backpressure: out_ready toggles 0/1 every cycle with continuous commits → no duplicated or lost entries; out_* stable during stalls; seq strictly increasing by 1.
- flush with 5 entries held plus a same-cycle commit → out_valid=0 next cycle, level=0, retired increments. clr_ovf coinciding with a drop → overflow=1, drop_cnt=1. rst_n pulse mid-stream → all outputs at reset values immediately.
